fifo_wr_rptr_sync: RTL and testbench

//  Write-domain receiver for the async FIFO's Gray read pointer: the read-to-write pointer crossing and its decode.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/gray_to_binary.sv | 14 +
 rtl/fifo_wr_rptr_sync.sv | 112 +++++++++++
 tb/tb_fifo_wr_rptr_sync.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write-side read-pointer receiver.
package fifo_pkg;

  localparam int DEF_ADD_WIDTH   = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_AF_THRESH   = 6;
  localparam int DEPTH           = 1 << DEF_ADD_WIDTH;

  typedef logic [DEF_ADD_WIDTH:0] ptr_t;

  // Encoder used by the pointer sources; gray_to_binary is its inverse.
  function automatic ptr_t binary_to_gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of
// the Gray bits at and above it.
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/fifo_wr_rptr_sync.sv
// Write-domain receiver for the async FIFO Gray read pointer.
// Synchronises rptr into wclk, decodes both pointers and registers the
// occupancy, free space, almost-full and coherence-error outputs.
// Optional sticky overflow flag: define FIFO_WR_OVF_EN.
module fifo_wr_rptr_sync
  import fifo_pkg::*;
#(
  parameter int ADD_WIDTH   = DEF_ADD_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AF_THRESH   = DEF_AF_THRESH
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [ADD_WIDTH:0] rptr,
  input  logic [ADD_WIDTH:0] wptr,
  input  logic               winc,
`ifdef FIFO_WR_OVF_EN
  input  logic               wovf_clr,
  output logic               wovf,
`endif
  output logic [ADD_WIDTH:0] wq2_rptr,
  output logic [ADD_WIDTH:0] wcount,
  output logic [ADD_WIDTH:0] wspace,
  output logic               walmost_full,
  output logic               wsync_err
);

  localparam int PW = ADD_WIDTH + 1;
  localparam logic [ADD_WIDTH:0] WDEPTH = PW'(1 << ADD_WIDTH);
  localparam logic [ADD_WIDTH:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [ADD_WIDTH:0] ONE    = PW'(1);

  logic [ADD_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADD_WIDTH:0] sync_d [SYNC_STAGES];
  logic [ADD_WIDTH:0] prev_q, prev_d;
  logic [ADD_WIDTH:0] wcount_q, wcount_d;
  logic [ADD_WIDTH:0] wspace_q, wspace_d;
  logic               waf_q, waf_d;
  logic               wsync_err_q, wsync_err_d;

  logic [ADD_WIDTH:0] rbin, wbin;
  logic [ADD_WIDTH:0] cnt_calc;
  logic [ADD_WIDTH:0] ptr_diff;
  logic               err;

  assign wq2_rptr = sync_q[SYNC_STAGES-1];

  gray_to_binary #(.WIDTH(PW)) u_rdec (.gray(wq2_rptr), .bin(rbin));
  gray_to_binary #(.WIDTH(PW)) u_wdec (.gray(wptr),     .bin(wbin));

  // Plain shift chain, nothing between the flops.
  always_comb begin
    sync_d[0] = rptr;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Occupancy of the post-edge write pointer; any incoherence forces full.
  always_comb begin
    cnt_calc    = wbin + {{ADD_WIDTH{1'b0}}, winc} - rbin;
    ptr_diff    = wq2_rptr ^ prev_q;
    err         = ((ptr_diff & (ptr_diff - ONE)) != '0) || (cnt_calc > WDEPTH);
    wcount_d    = err ? WDEPTH : cnt_calc;
    wspace_d    = WDEPTH - wcount_d;
    waf_d       = (wcount_d >= AF_LVL);
    wsync_err_d = err;
    prev_d      = wq2_rptr;
  end

  // Sync chain and all write-side status registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q      <= '0;
      wcount_q    <= '0;
      wspace_q    <= WDEPTH;
      waf_q       <= 1'b0;
      wsync_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      wcount_q    <= wcount_d;
      wspace_q    <= wspace_d;
      waf_q       <= waf_d;
      wsync_err_q <= wsync_err_d;
    end
  end

  assign wcount       = wcount_q;
  assign wspace       = wspace_q;
  assign walmost_full = waf_q;
  assign wsync_err    = wsync_err_q;

`ifdef FIFO_WR_OVF_EN
  logic wovf_q, wovf_d;

  // Sticky overflow: a write while already full sets it; set beats clear.
  always_comb begin
    wovf_d = wovf_q;
    if (winc && (wcount_q == WDEPTH)) wovf_d = 1'b1;
    else if (wovf_clr)                wovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) wovf_q <= 1'b0;
    else         wovf_q <= wovf_d;
  end

  assign wovf = wovf_q;
`endif

endmodule

// File: tb/tb_fifo_wr_rptr_sync.sv
// Directed bench for fifo_wr_rptr_sync (ADD_WIDTH=3, SYNC_STAGES=2, AF_THRESH=6).
module tb_fifo_wr_rptr_sync;

  logic       wclk   = 1'b0;
  logic       wrst_n = 1'b0;
  logic [3:0] rptr   = 4'd0;
  logic [3:0] wptr   = 4'd0;
  logic       winc   = 1'b0;
  logic [3:0] wq2_rptr, wcount, wspace;
  logic       walmost_full, wsync_err;
`ifdef FIFO_WR_OVF_EN
  logic       wovf_clr = 1'b0;
  logic       wovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int wb    = 0;
  int rtab [8] = '{7, 8, 9, 10, 11, 12, 12, 12};
  int itab [8] = '{0, 0, 1, 1, 1, 1, 1, 1};

  always #5 wclk = ~wclk;

  fifo_wr_rptr_sync #(.ADD_WIDTH(3), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .rptr(rptr),
    .wptr(wptr),
    .winc(winc),
`ifdef FIFO_WR_OVF_EN
    .wovf_clr(wovf_clr),
    .wovf(wovf),
`endif
    .wq2_rptr(wq2_rptr),
    .wcount(wcount),
    .wspace(wspace),
    .walmost_full(walmost_full),
    .wsync_err(wsync_err)
  );

  function automatic logic [3:0] g(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic write_pulse();
    winc = 1'b1;
    wptr = g(wb);
    tick();
    wb++;
    wptr = g(wb);
    winc = 1'b0;
  endtask

  initial begin
    // reset with a non-zero rptr present
    rptr = 4'b0110;
    wrst_n = 1'b0;
    repeat (3) tick();
    check("rst_wq2",   8'(wq2_rptr),     8'd0);
    check("rst_cnt",   8'(wcount),       8'd0);
    check("rst_space", 8'(wspace),       8'd8);
    check("rst_af",    8'(walmost_full), 8'd0);
    check("rst_err",   8'(wsync_err),    8'd0);
`ifdef FIFO_WR_OVF_EN
    check("rst_ovf",   8'(wovf),         8'd0);
`endif
    rptr = 4'd0;
    tick();
    wrst_n = 1'b1;
    repeat (3) tick();
    check("idle_cnt", 8'(wcount),    8'd0);
    check("idle_err", 8'(wsync_err), 8'd0);

    // fill from empty, rptr static
    repeat (5) write_pulse();
    check("fill5_cnt", 8'(wcount),       8'd5);
    check("fill5_af",  8'(walmost_full), 8'd0);
    write_pulse();
    check("fill6_cnt",   8'(wcount),       8'd6);
    check("fill6_af",    8'(walmost_full), 8'd1);
    check("fill6_space", 8'(wspace),       8'd2);
    write_pulse();
    write_pulse();
    check("fill8_cnt",   8'(wcount),    8'd8);
    check("fill8_space", 8'(wspace),    8'd0);
    check("fill8_err",   8'(wsync_err), 8'd0);
    tick();
    check("hold8_cnt", 8'(wcount), 8'd8);

    // sync latency of a single rptr step
    rptr = g(1);
    tick();
    check("lat1_wq2", 8'(wq2_rptr), 8'd0);
    tick();
    check("lat2_wq2", 8'(wq2_rptr), 8'b0001);
    check("lat2_cnt", 8'(wcount),   8'd8);
    tick();
    check("lat3_cnt",   8'(wcount),       8'd7);
    check("lat3_space", 8'(wspace),       8'd1);
    check("lat3_af",    8'(walmost_full), 8'd1);

    // read advances to 5, then write to wbin=11 -> count 6
    for (int r = 2; r <= 5; r++) begin
      rptr = g(r);
      tick();
    end
    repeat (3) tick();
    check("rd5_cnt", 8'(wcount),       8'd3);
    check("rd5_af",  8'(walmost_full), 8'd0);
    repeat (3) write_pulse();
    check("w11_cnt", 8'(wcount),       8'd6);
    check("w11_af",  8'(walmost_full), 8'd1);

    // read step reaches wq2 on the same edge as a write
    rptr = g(6);
    tick();
    tick();
    check("simul_pre", 8'(wcount), 8'd6);
    write_pulse();
    check("simul_cnt", 8'(wcount),    8'd6);
    check("simul_err", 8'(wsync_err), 8'd0);

    // streaming through the 1111->0000 wrap
    for (int i = 0; i < 8; i++) begin
      rptr = g(rtab[i]);
      winc = itab[i][0];
      wptr = g(wb);
      tick();
      if (itab[i] != 0) wb++;
      wptr = g(wb);
      check($sformatf("wrap_%0d", i), 8'(wcount), 8'd6);
    end
    winc = 1'b0;
    tick();
    check("wrap_end_cnt", 8'(wcount),    8'd6);
    check("wrap_end_err", 8'(wsync_err), 8'd0);

    // async reset mid-operation, no clock edge
    wrst_n = 1'b0;
    #2;
    check("arst_cnt",   8'(wcount),       8'd0);
    check("arst_space", 8'(wspace),       8'd8);
    check("arst_wq2",   8'(wq2_rptr),     8'd0);
    check("arst_af",    8'(walmost_full), 8'd0);
    rptr = 4'd0;
    wb = 0;
    wptr = 4'd0;
    tick();
    wrst_n = 1'b1;
    repeat (3) tick();
    check("rel_cnt", 8'(wcount), 8'd0);

    // multi-bit jump on wq2_rptr
    write_pulse();
    write_pulse();
    rptr = 4'b0011;
    tick();
    tick();
    check("jump_wq2",  8'(wq2_rptr),  8'b0011);
    check("jump_err0", 8'(wsync_err), 8'd0);
    check("jump_cnt0", 8'(wcount),    8'd2);
    tick();
    check("jump_err",   8'(wsync_err),    8'd1);
    check("jump_cnt",   8'(wcount),       8'd8);
    check("jump_space", 8'(wspace),       8'd0);
    check("jump_af",    8'(walmost_full), 8'd1);
    tick();
    check("jump_err_off", 8'(wsync_err), 8'd0);
    check("jump_cnt_ok",  8'(wcount),    8'd0);

    // read pointer passing the write pointer -> count > DEPTH
    rptr = g(3);
    repeat (3) tick();
    check("over_err", 8'(wsync_err), 8'd1);
    check("over_cnt", 8'(wcount),    8'd8);
    rptr = g(2);
    repeat (3) tick();
    check("over_rec_err", 8'(wsync_err), 8'd0);
    check("over_rec_cnt", 8'(wcount),    8'd0);

`ifdef FIFO_WR_OVF_EN
    repeat (8) write_pulse();
    check("ovf_full_cnt", 8'(wcount), 8'd8);
    check("ovf_pre",      8'(wovf),   8'd0);
    write_pulse();
    check("ovf_set", 8'(wovf), 8'd1);
    tick();
    check("ovf_hold", 8'(wovf), 8'd1);
    wovf_clr = 1'b1;
    write_pulse();
    check("ovf_set_beats_clr", 8'(wovf), 8'd1);
    tick();
    check("ovf_clr", 8'(wovf), 8'd0);
    wovf_clr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
